// File: rtl/dcache_wb_if.sv
// Bundle of CPU-side and memory-side signals of the direct-mapped write-back data cache.
// The slave modport is the cache's view; the master modport is the CPU/memory environment's view.
interface dcache_wb_if;
  logic         proc_read;
  logic         proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  modport slave (
    input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
    output proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
    input  proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_wb.sv
// Direct-mapped, write-back, write-allocate data cache: 8 lines x 4 words x 32 bits.
// Define DCACHE_PERF_CNT_EN to add saturating hit_cnt/miss_cnt outputs.
module dcache_wb (
  input  logic        clk,
  input  logic        rst_n,
  dcache_wb_if.slave  bus
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WB    = 2'd1;
  localparam logic [1:0] S_ALLOC = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [7:0]   valid_q, dirty_q;
  logic [24:0]  tag_q  [8];
  logic [127:0] data_q [8];

  logic [1:0]   off;
  logic [2:0]   idx;
  logic [24:0]  tag;
  logic         req, hit, fill, wr_hit;
  logic [127:0] line_data;
  logic [127:0] merged_line;

  assign off = bus.proc_addr[1:0];
  assign idx = bus.proc_addr[4:2];
  assign tag = bus.proc_addr[29:5];

  // A simultaneous read+write is handled as a write because only proc_write gates the update.
  assign req       = bus.proc_read | bus.proc_write;
  assign line_data = data_q[idx];
  assign hit       = req & valid_q[idx] & (tag_q[idx] == tag);
  assign fill      = (state_q == S_ALLOC) & bus.mem_ready;
  assign wr_hit    = (state_q == S_IDLE) & hit & bus.proc_write;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_merge
      assign merged_line[32*gi +: 32] = (off == 2'(gi)) ? bus.proc_wdata
                                                         : line_data[32*gi +: 32];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req && !hit)
          state_d = (valid_q[idx] && dirty_q[idx]) ? S_WB : S_ALLOC;
      end
      S_WB: begin
        if (bus.mem_ready)
          state_d = S_ALLOC;
      end
      S_ALLOC: begin
        if (bus.mem_ready)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Only control state is reset; tag/data are qualified by valid and need no reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      if (fill) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end else if (wr_hit) begin
        dirty_q[idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      tag_q[idx]  <= tag;
      data_q[idx] <= bus.mem_rdata;
    end else if (wr_hit) begin
      data_q[idx] <= merged_line;
    end
  end

  assign bus.mem_write  = (state_q == S_WB);
  assign bus.mem_read   = (state_q == S_ALLOC);
  assign bus.mem_addr   = (state_q == S_WB) ? {tag_q[idx], idx} : {tag, idx};
  assign bus.mem_wdata  = line_data;
  assign bus.proc_stall = (state_q == S_IDLE) ? (req & ~hit) : 1'b1;
  assign bus.proc_rdata = line_data[{off, 5'b0} +: 32];

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  logic        retry_q;

  // retry_q marks the first IDLE cycle after a fill, whose hit is the replayed miss.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      retry_q    <= 1'b0;
    end else begin
      retry_q <= fill;
      if ((state_q == S_IDLE) && req && !hit && (miss_cnt_q != 32'hFFFF_FFFF))
        miss_cnt_q <= miss_cnt_q + 32'd1;
      if ((state_q == S_IDLE) && hit && !retry_q && (hit_cnt_q != 32'hFFFF_FFFF))
        hit_cnt_q <= hit_cnt_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: doc/dcache_wb.md
DCACHE_WB -- requirements
Module: dcache_wb

Interface
REQ-001 The block SHALL have no parameters; geometry is fixed at 8 lines x 4 words x 32 bits, direct-mapped, write-back, write-allocate.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- proc_read  in  1  CPU load request.
- proc_write  in  1  CPU store request.
- proc_addr  in  30  CPU word address.
- proc_wdata  in  32  store data.
- proc_stall  out  1  CPU must hold its request.
- proc_rdata  out  32  load data.
- mem_read  out  1  block fill request.
- mem_write  out  1  block writeback request.
- mem_addr  out  28  memory block address.
- mem_wdata  out  128  writeback block.
- mem_rdata  in  128  fill block.
- mem_ready  in  1  one-cycle completion pulse from memory.
REQ-003 There SHALL be one clock, clk; reset SHALL be rst_n, asynchronous and active-low.

Function
REQ-004 Address split SHALL be: offset = proc_addr[1:0], index = proc_addr[4:2], tag = proc_addr[29:5] (25 bits).
REQ-005 Per line, storage SHALL be: valid, dirty, 25-bit tag, 128-bit data; word w occupies data[32w+31:32w].
REQ-006 FSM states SHALL be: IDLE, WRITEBACK, ALLOCATE.
REQ-007 Hit = request active, line valid, stored tag == tag; in IDLE, proc_stall SHALL be 0 combinationally on a hit and 1 on a miss.
REQ-008 On a read hit, proc_rdata SHALL be the addressed word in the same cycle (zero-latency, combinational).
REQ-009 On a write hit, the addressed word SHALL be updated and dirty set at the next edge.
REQ-010 On a miss in IDLE: go to WRITEBACK if line valid and dirty, else ALLOCATE.
REQ-011 In WRITEBACK: mem_write=1, mem_addr={stored tag,index}, mem_wdata=line data; on mem_ready go to ALLOCATE.
REQ-012 In ALLOCATE: mem_read=1, mem_addr={tag,index}; on mem_ready, line takes mem_rdata, tag, valid=1, dirty=0, and the FSM returns to IDLE.
REQ-013 mem_read/mem_write SHALL be registered-state decodes, deasserted in the cycle after mem_ready, and never both 1.
REQ-014 proc_stall SHALL be 1 throughout WRITEBACK and ALLOCATE; the retried access in IDLE then hits.
REQ-015 Write miss SHALL allocate first, then perform the write as a hit in IDLE.
REQ-016 proc_read and proc_write both 1 SHALL be treated as a write.
REQ-017 With no request, proc_stall SHALL be 0; proc_rdata is don't-care.
REQ-018 Input changes while stalled are illegal; the cache SHALL use the current proc_addr and need not latch it.

Reset
REQ-019 rst_n low SHALL immediately force state=IDLE, mem_read=0, mem_write=0, and all valid/dirty=0; tag and data contents are unspecified.
REQ-020 Reset mid-WRITEBACK/ALLOCATE SHALL abandon the transfer with no line update; proc_stall SHALL reflect the cleared state (a request now misses).

Configuration
REQ-021 When the macro DCACHE_PERF_CNT_EN is defined, outputs hit_cnt[31:0] and miss_cnt[31:0] SHALL exist, each reset to 0 and saturating at 0xFFFFFFFF.
REQ-022 miss_cnt SHALL count +1 per IDLE->WRITEBACK/ALLOCATE transition; hit_cnt SHALL count +1 per IDLE hit, excluding the retry hit in the first IDLE cycle after ALLOCATE.
REQ-023 Without the macro, the ports and counters SHALL be absent and behaviour SHALL otherwise be identical.

Verification
REQ-024 After reset, read 0x0000010 -> proc_stall=1, mem_read=1, mem_addr=0x0000004; mem_ready with rdata word0=0xAAAA0000 -> next cycle proc_stall=0, proc_rdata=0xAAAA0000.
REQ-025 Write 0x12345678 to 0x0000011 (hit) -> no stall; subsequent read of 0x0000011 returns 0x12345678.
REQ-026 Read 0x0000111 (same index 4, new tag, dirty line) -> mem_write=1, mem_addr=0x0000004, mem_wdata[63:32]=0x12345678, then mem_read with mem_addr=0x0000044.
REQ-027 Assert rst_n=0 during ALLOCATE -> mem_read drops asynchronously; a post-reset read of the same address misses.
REQ-028 Hold mem_ready=0 for 20 cycles in WRITEBACK -> mem_write and proc_stall stay 1, with no state change.
REQ-029 With DCACHE_PERF_CNT_EN: sequence REQ-024..026 -> miss_cnt=2, hit_cnt=2.
